// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline instruction interface.
// The instruction struct is what travels through the issue FIFO and onto the pipeline.
package pipe_pkg;

    localparam int REG_W  = 4;
    localparam int FUNC_W = 4;
    localparam int ADDR_W = 8;

    localparam logic [FUNC_W-1:0] FN_ADD = 4'd0;
    localparam logic [FUNC_W-1:0] FN_SUB = 4'd1;
    localparam logic [FUNC_W-1:0] FN_MUL = 4'd2;
    localparam logic [FUNC_W-1:0] FN_SLA = 4'd11;

    typedef struct packed {
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic [REG_W-1:0]  rd;
        logic [FUNC_W-1:0] func;
        logic [ADDR_W-1:0] addr;
    } instr_t;

endpackage

// File: rtl/pipe_issue_unit_if.sv
// Instruction handshake into the issue unit and issued-instruction fields out of it.
// master is the producer/consumer side, slave is the issue unit itself.
interface pipe_issue_unit_if;
    import pipe_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [REG_W-1:0]  in_rs1;
    logic [REG_W-1:0]  in_rs2;
    logic [REG_W-1:0]  in_rd;
    logic [FUNC_W-1:0] in_func;
    logic [ADDR_W-1:0] in_addr;

    logic              out_valid;
    logic [REG_W-1:0]  out_rs1;
    logic [REG_W-1:0]  out_rs2;
    logic [REG_W-1:0]  out_rd;
    logic [FUNC_W-1:0] out_func;
    logic [ADDR_W-1:0] out_addr;

    modport master (
        output in_valid, in_rs1, in_rs2, in_rd, in_func, in_addr,
        input  in_ready,
        input  out_valid, out_rs1, out_rs2, out_rd, out_func, out_addr
    );

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_rd, in_func, in_addr,
        output in_ready,
        output out_valid, out_rs1, out_rs2, out_rd, out_func, out_addr
    );

endinterface

// File: rtl/issue_fifo.sv
// Synchronous FIFO of instructions with a registered occupancy count.
// head is the entry at the read pointer; it is only meaningful while !empty.
module issue_fifo
    import pipe_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk1,
    input  logic   rst_n,
    input  logic   push,
    input  logic   pop,
    input  instr_t din,
    output instr_t head,
    output logic   full,
    output logic   empty
);

    localparam int              PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(DEPTH);

    instr_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is data only and needs no reset; occupancy guards every read.
    always_ff @(posedge clk1) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/pipe_issue_unit.sv
// Issue front end: buffers instructions and issues at most one per clock,
// inserting bubbles while a source matches the rd of a recently issued instruction.
module pipe_issue_unit
    import pipe_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int HAZARD_WIN = 2,
    parameter int CNT_W      = 16
) (
    input  logic                 clk1,
    input  logic                 rst_n,
    pipe_issue_unit_if.slave     bus,
    output logic                 busy,
    output logic [CNT_W-1:0]     issue_count,
    output logic [CNT_W-1:0]     stall_count
);

    // A zero-length window still needs one physical slot; it is masked out below.
    localparam int SB_N = (HAZARD_WIN > 0) ? HAZARD_WIN : 1;

    instr_t           in_p0;
    instr_t           head_p0;
    instr_t           issue_p1;
    logic             vld_p1;
    logic             full;
    logic             empty;
    logic             hit;
    logic             hazard;
    logic             pop;
    logic [SB_N-1:0]  sb_vld;
    logic [REG_W-1:0] sb_rd [SB_N];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign in_p0 = '{rs1: bus.in_rs1, rs2: bus.in_rs2, rd: bus.in_rd,
                     func: bus.in_func, addr: bus.in_addr};

    issue_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk1  (clk1),
        .rst_n (rst_n),
        .push  (bus.in_valid && bus.in_ready),
        .pop   (pop),
        .din   (in_p0),
        .head  (head_p0),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < SB_N; i++) begin
            if (HAZARD_WIN > 0 && sb_vld[i] &&
                (sb_rd[i] == head_p0.rs1 || sb_rd[i] == head_p0.rs2))
                hit = 1'b1;
        end
    end

    assign hazard       = !empty && hit;
    assign pop          = !empty && !hazard;
    assign bus.in_ready = !full;
    assign busy         = !empty || (HAZARD_WIN > 0 && (|sb_vld));

    // Stage p0 -> p1: issue register, scoreboard shift and statistics.
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            vld_p1      <= 1'b0;
            issue_p1    <= '0;
            sb_vld      <= '0;
            issue_count <= '0;
            stall_count <= '0;
        end else begin
            vld_p1 <= pop;
            if (pop) begin
                issue_p1    <= head_p0;
                issue_count <= issue_count + 1'b1;
            end
            if (hazard) stall_count <= sat_inc(stall_count);
            for (int i = SB_N - 1; i > 0; i--) sb_vld[i] <= sb_vld[i-1];
            sb_vld[0] <= pop;
        end
    end

    always_ff @(posedge clk1) begin
        for (int i = SB_N - 1; i > 0; i--) sb_rd[i] <= sb_rd[i-1];
        sb_rd[0] <= head_p0.rd;
    end

    assign bus.out_valid = vld_p1;
    assign bus.out_rs1   = issue_p1.rs1;
    assign bus.out_rs2   = issue_p1.rs2;
    assign bus.out_rd    = issue_p1.rd;
    assign bus.out_func  = issue_p1.func;
    assign bus.out_addr  = issue_p1.addr;

endmodule

// File: tb/tb_pipe_issue_unit.sv
// Scoreboard bench for pipe_issue_unit: one instance with a 2-deep hazard window,
// one with the interlock disabled, driven by directed instruction sequences.
module tb_pipe_issue_unit;
    import pipe_pkg::*;

    logic clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    logic        rst_n;
    logic        busy_a, busy_b;
    logic [15:0] ic_a, sc_a, ic_b, sc_b;

    pipe_issue_unit_if bus_a ();
    pipe_issue_unit_if bus_b ();

    pipe_issue_unit #(.DEPTH(4), .HAZARD_WIN(2), .CNT_W(16)) u_a (
        .clk1(clk1), .rst_n(rst_n), .bus(bus_a),
        .busy(busy_a), .issue_count(ic_a), .stall_count(sc_a)
    );

    pipe_issue_unit #(.DEPTH(4), .HAZARD_WIN(0), .CNT_W(16)) u_b (
        .clk1(clk1), .rst_n(rst_n), .bus(bus_b),
        .busy(busy_b), .issue_count(ic_b), .stall_count(sc_b)
    );

    int     n_chk = 0;
    int     n_fail = 0;
    int     cyc = 0;
    instr_t exp_a[$], exp_b[$];
    int     icyc_a[$], icyc_b[$];
    int     acc_n[2] = '{0, 0};
    int     iss_n[2] = '{0, 0};
    instr_t last[2];
    bit     saw_full;

    always @(posedge clk1) cyc <= cyc + 1;

    function automatic instr_t mk(input int rs1, input int rs2, input int rd,
                                  input logic [3:0] fn, input int addr);
        return '{rs1: 4'(rs1), rs2: 4'(rs2), rd: 4'(rd), func: fn, addr: 8'(addr)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got event, expected none", name);
    endtask

    // Monitor: every non-reset cycle either an issue (pop and compare) or a held bubble.
    task automatic mon_one(input int sel, input logic v, input logic rdy, input instr_t got);
        instr_t e;
        bit     have;
        have = 0;
        if (v) begin
            iss_n[sel]++;
            if (sel == 0) begin
                icyc_a.push_back(cyc);
                if (exp_a.size() != 0) begin e = exp_a.pop_front(); have = 1; end
            end else begin
                icyc_b.push_back(cyc);
                if (exp_b.size() != 0) begin e = exp_b.pop_front(); have = 1; end
            end
            if (!have) fail($sformatf("unexpected_issue[%0d] fields=%06h", sel, got));
            else check($sformatf("issue_fields[%0d]", sel), got, e);
            last[sel] = got;
        end else begin
            check($sformatf("bubble_hold[%0d]", sel), got, last[sel]);
        end
        check($sformatf("in_ready[%0d]", sel), rdy, (acc_n[sel] - iss_n[sel]) < 4);
        if (sel == 0 && !rdy) saw_full = 1;
    endtask

    always @(negedge clk1) begin
        if (!rst_n) begin
            last[0] = '0;
            last[1] = '0;
        end else begin
            mon_one(0, bus_a.out_valid, bus_a.in_ready,
                    {bus_a.out_rs1, bus_a.out_rs2, bus_a.out_rd, bus_a.out_func, bus_a.out_addr});
            mon_one(1, bus_b.out_valid, bus_b.in_ready,
                    {bus_b.out_rs1, bus_b.out_rs2, bus_b.out_rd, bus_b.out_func, bus_b.out_addr});
        end
    end

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic drive_fields(input instr_t ins);
        {bus_a.in_rs1, bus_a.in_rs2, bus_a.in_rd, bus_a.in_func, bus_a.in_addr} = ins;
        {bus_b.in_rs1, bus_b.in_rs2, bus_b.in_rd, bus_b.in_func, bus_b.in_addr} = ins;
    endtask

    // Offer one instruction and hold it until accepted; acc_cyc is the accepting edge.
    task automatic push(input int sel, input instr_t ins, output int acc_cyc);
        int w;
        w = 0;
        acc_cyc = -1;
        drive_fields(ins);
        if (sel == 0) bus_a.in_valid = 1'b1;
        else          bus_b.in_valid = 1'b1;
        while (((sel == 0) ? bus_a.in_ready : bus_b.in_ready) !== 1'b1 && w <= 60) begin
            step();
            w++;
        end
        if (w > 60) begin
            fail($sformatf("push_timeout[%0d]", sel));
        end else begin
            if (sel == 0) exp_a.push_back(ins);
            else          exp_b.push_back(ins);
            step();
            acc_n[sel]++;
            acc_cyc = cyc;
        end
        bus_a.in_valid = 1'b0;
        bus_b.in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int sel);
        int w;
        w = 0;
        while (((sel == 0) ? busy_a : busy_b) !== 1'b0 && w < 100) begin
            step();
            w++;
        end
        if (w >= 100) fail($sformatf("idle_timeout[%0d]", sel));
        step();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready_a"},  bus_a.in_ready, 1);
        check({tag, "_out_valid_a"}, bus_a.out_valid, 0);
        check({tag, "_out_fields_a"},
              {bus_a.out_rs1, bus_a.out_rs2, bus_a.out_rd, bus_a.out_func, bus_a.out_addr}, 0);
        check({tag, "_busy_a"},        busy_a, 0);
        check({tag, "_issue_count_a"}, ic_a, 0);
        check({tag, "_stall_count_a"}, sc_a, 0);
        check({tag, "_in_ready_b"},    bus_b.in_ready, 1);
        check({tag, "_out_valid_b"},   bus_b.out_valid, 0);
        check({tag, "_busy_b"},        busy_b, 0);
        check({tag, "_issue_count_b"}, ic_b, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got time limit, expected completion");
        $fatal(1, "bench time limit");
    end

    initial begin
        int a0, a1, a2, t;

        // Reset held two cycles with valid asserted.
        rst_n = 1'b0;
        drive_fields(mk(1, 2, 3, FN_SUB, 5));
        bus_a.in_valid = 1'b1;
        bus_b.in_valid = 1'b1;
        step();
        step();
        check_reset_state("reset");
        bus_a.in_valid = 1'b0;
        bus_b.in_valid = 1'b0;
        rst_n = 1'b1;
        step();
        check_reset_state("post_reset");

        // Independent stream: back-to-back issue.
        icyc_a.delete();
        push(0, mk(3, 5, 10, FN_ADD, 125), a0);
        push(0, mk(3, 8, 12, FN_MUL, 126), a1);
        push(0, mk(7, 3, 13, FN_SLA, 127), a2);
        wait_idle(0);
        check("stream_n_issued", icyc_a.size(), 3);
        if (icyc_a.size() >= 3) begin
            check("stream_lat0", icyc_a[0], a0 + 1);
            check("stream_lat1", icyc_a[1], a1 + 1);
            check("stream_lat2", icyc_a[2], a2 + 1);
        end
        check("stream_issue_count", ic_a, 3);
        check("stream_stall_count", sc_a, 0);

        // RAW hazard: SUB reads r10 two issues after ADD wrote it.
        icyc_a.delete();
        push(0, mk(3, 5, 10, FN_ADD, 125), a0);
        push(0, mk(3, 8, 12, FN_MUL, 126), a1);
        push(0, mk(10, 5, 14, FN_SUB, 128), a2);
        wait_idle(0);
        check("raw_n_issued", icyc_a.size(), 3);
        if (icyc_a.size() >= 3) begin
            check("raw_lat0", icyc_a[0], a0 + 1);
            check("raw_lat1", icyc_a[1], a1 + 1);
            check("raw_sub_after_bubble", icyc_a[2], a2 + 2);
        end
        check("raw_issue_count", ic_a, 6);
        check("raw_stall_count", sc_a, 1);

        // Same sequence with the interlock disabled.
        icyc_b.delete();
        push(1, mk(3, 5, 10, FN_ADD, 125), a0);
        push(1, mk(3, 8, 12, FN_MUL, 126), a1);
        push(1, mk(10, 5, 14, FN_SUB, 128), a2);
        wait_idle(1);
        check("win0_n_issued", icyc_b.size(), 3);
        if (icyc_b.size() >= 3) begin
            check("win0_lat0", icyc_b[0], a0 + 1);
            check("win0_lat1", icyc_b[1], a1 + 1);
            check("win0_lat2", icyc_b[2], a2 + 1);
        end
        check("win0_issue_count", ic_b, 3);
        check("win0_stall_count", sc_b, 0);

        // Dependency chain stalls the head long enough for the FIFO to fill.
        saw_full = 0;
        push(0, mk(0, 0, 1, FN_ADD, 10), t);
        push(0, mk(1, 0, 2, FN_SUB, 11), t);
        push(0, mk(2, 0, 3, FN_MUL, 12), t);
        push(0, mk(0, 3, 4, FN_SLA, 13), t);
        push(0, mk(4, 0, 5, FN_ADD, 14), t);
        push(0, mk(0, 5, 6, FN_SUB, 15), t);
        push(0, mk(6, 0, 7, FN_MUL, 16), t);
        wait_idle(0);
        check("full_seen_not_ready", saw_full, 1);
        check("full_issue_count", ic_a, 13);

        // Reset with three entries queued drops them all.
        push(0, mk(0, 0, 1, FN_ADD, 20), t);
        push(0, mk(1, 1, 2, FN_SUB, 21), t);
        push(0, mk(2, 0, 3, FN_MUL, 22), t);
        push(0, mk(3, 0, 4, FN_SLA, 23), t);
        check("mid_busy_before_reset", busy_a, 1);
        rst_n = 1'b0;
        step();
        exp_a.delete();
        acc_n[0] = iss_n[0];
        check_reset_state("mid_reset");
        rst_n = 1'b1;
        icyc_a.delete();
        push(0, mk(9, 9, 15, FN_ADD, 200), a0);
        wait_idle(0);
        check("mid_n_issued", icyc_a.size(), 1);
        if (icyc_a.size() >= 1) check("mid_lat", icyc_a[0], a0 + 1);
        check("mid_issue_count", ic_a, 1);

        check("drained_a", exp_a.size(), 0);
        check("drained_b", exp_b.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
